// File: rtl/da_rom_loader_if.sv
// da_rom_loader_if: coefficient-write, start/hold control and ROM load stream of da_rom_loader
interface da_rom_loader_if #(
    parameter int COEF_W = 16,
    parameter int CIN_W = 20
);
    logic                     coef_we;
    logic [5:0]               coef_idx;
    logic signed [COEF_W-1:0] coef_data;
    logic                     start;
    logic                     hold;
    logic [10:0]              CADDR;
    logic signed [CIN_W-1:0]  CIN;
    logic                     CLOAD;
    logic                     valid_in;
    logic                     busy;
    logic                     done;
    modport master (
        input  coef_we, coef_idx, coef_data, start, hold,
        output CADDR, CIN, CLOAD, valid_in, busy, done
    );
    modport slave (
        output coef_we, coef_idx, coef_data, start, hold,
        input  CADDR, CIN, CLOAD, valid_in, busy, done
    );
endinterface

// File: rtl/da_rom_loader.sv
// da_rom_loader: builds the 2048 DA partial sums from 64 taps and streams them into da
module da_rom_loader #(
    parameter int COEF_W = 16,
    parameter int CIN_W = 20
) (
    input logic clk,
    input logic reset,
    da_rom_loader_if.master bus
);
    localparam int PW = COEF_W + 1;
    localparam int SW = COEF_W + 3;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic signed [COEF_W-1:0] coef [64];
    logic signed [PW-1:0] p [4];
    logic signed [PW-1:0] p_n [4];
    logic signed [SW-1:0] sum;
    logic [10:0] cnt, a1;
    logic v1, cload_q;
    always_comb begin
        state_n = (state == IDLE && bus.start) ? RUN :
                  (state == RUN && !bus.hold && cnt == 11'd2047) ? DRAIN :
                  (state == DRAIN && cload_q && !v1 && !bus.hold) ? DONE :
                  (state == DONE) ? IDLE : state;
    end
    // Taps of ROM r live at coef[8r..8r+7]; address bit k selects tap 8r+k
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            p_n[j] = (cnt[2*j] ? PW'(coef[{cnt[10:8], 3'(2*j)}]) : '0) +
                     (cnt[2*j+1] ? PW'(coef[{cnt[10:8], 3'(2*j+1)}]) : '0);
        end
    end
    assign sum = SW'(p[0]) + SW'(p[1]) + SW'(p[2]) + SW'(p[3]);
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            a1        <= '0;
            v1        <= 1'b0;
            cload_q   <= 1'b0;
            p         <= '{default: '0};
            coef      <= '{default: '0};
            bus.CADDR <= '0;
            bus.CIN   <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && bus.coef_we) coef[bus.coef_idx] <= bus.coef_data;
            if (state == IDLE && bus.start) cnt <= '0;
            else if (state == RUN && !bus.hold) cnt <= cnt + 11'd1;
            if (!bus.hold) begin
                v1        <= state == RUN;
                a1        <= cnt;
                p         <= p_n;
                cload_q   <= v1;
                bus.CADDR <= a1;
                bus.CIN   <= CIN_W'(sum);
            end
        end
    end
    assign bus.CLOAD    = cload_q & ~bus.hold;
    assign bus.valid_in = cload_q & ~bus.hold;
    assign bus.busy     = state == RUN || state == DRAIN;
    assign bus.done     = state == DONE;
endmodule

// File: tb/tb_da_rom_loader.sv
// tb_da_rom_loader: scoreboard of every streamed word plus a spot-check vector table
module tb_da_rom_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    da_rom_loader_if #(.COEF_W(16), .CIN_W(20)) bus ();
    da_rom_loader #(.COEF_W(16), .CIN_W(20)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct { int addr; int cin; } word_t;
    typedef struct { int mode; int addr; int cin; } vec_t;
    word_t sb[$];
    vec_t vecs [13];
    int mcoef [64];
    int got [2048];
    int checks = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model(input int a);
        int s = 0;
        for (int k = 0; k < 8; k++) if (a[k]) s += mcoef[(a >> 8) * 8 + k];
        return s;
    endfunction

    function automatic int coef_val(input int mode, input int i);
        case (mode)
            1: return 1;
            2: return -32768;
            3: return 32767;
            4: return i == 13 ? 100 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic load(input int mode, input int skip);
        for (int i = 0; i < 64; i++) begin
            if (i != skip) begin
                bus.coef_we = 1'b1;
                bus.coef_idx = 6'(i);
                bus.coef_data = 16'(coef_val(mode, i));
                mcoef[i] = coef_val(mode, i);
                @(negedge clk);
            end
        end
        bus.coef_we = 1'b0;
    endtask

    task automatic push_all();
        sb.delete();
        for (int a = 0; a < 2048; a++) sb.push_back('{a, model(a)});
    endtask

    task automatic pop_chk();
        word_t w;
        if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL sb_underflow: got word at CADDR %0d expected none", bus.CADDR);
            return;
        end
        w = sb.pop_front();
        chk("caddr", int'(bus.CADDR), w.addr);
        chk("cin", int'(bus.CIN), w.cin);
        chk("valid_in", int'(bus.valid_in), 1);
        got[w.addr] = int'(bus.CIN);
    endtask

    task automatic run_stream(input int hold_at, input int wr_idx, input int wr_val);
        int cyc = 0;
        int first = -1;
        int cloads = 0;
        int hold_left = 0;
        int dones = 0;
        bit held = 1'b0;
        bus.start = 1'b1;
        if (wr_idx >= 0) begin
            bus.coef_we = 1'b1;
            bus.coef_idx = 6'(wr_idx);
            bus.coef_data = 16'(wr_val);
            mcoef[wr_idx] = wr_val;
        end
        push_all();
        @(negedge clk);
        bus.start = 1'b0;
        bus.coef_we = 1'b0;
        chk("busy_e0", int'(bus.busy), 1);
        chk("cload_e0", int'(bus.CLOAD), 0);
        while (dones == 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (hold_left > 0) begin
                chk("hold_cload", int'(bus.CLOAD), 0);
                chk("hold_caddr", int'(bus.CADDR), hold_at);
                hold_left--;
                if (hold_left > 0) continue;
                bus.hold = 1'b0;
                #1;
            end
            if (bus.done) begin
                dones++;
                chk("done_busy", int'(bus.busy), 0);
                chk("cload_count", cloads, 2048);
            end else if (bus.CLOAD) begin
                if (first < 0) first = cyc;
                if (int'(bus.CADDR) == hold_at && !held) begin
                    held = 1'b1;
                    bus.hold = 1'b1;
                    hold_left = 5;
                    #1;
                    chk("hold_gate", int'(bus.CLOAD), 0);
                end else begin
                    pop_chk();
                    cloads++;
                end
            end else if (first >= 0) begin
                chk("gap_cload", int'(bus.CLOAD), 1);
            end
        end
        chk("first_cload_cyc", first, 2);
        chk("done_seen", dones, 1);
        chk("sb_empty", sb.size(), 0);
        @(negedge clk);
        chk("done_pulse", int'(bus.done), 0);
        chk("idle_busy", int'(bus.busy), 0);
    endtask

    task automatic run_abort();
        int cyc = 0;
        bit hit = 1'b0;
        bus.start = 1'b1;
        push_all();
        @(negedge clk);
        bus.start = 1'b0;
        while (!hit && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            bus.coef_we = 1'b0;
            if (bus.CLOAD) begin
                pop_chk();
                if (int'(bus.CADDR) == 500) begin
                    bus.coef_we = 1'b1;
                    bus.coef_idx = 6'd9;
                    bus.coef_data = 16'sd777;
                end
                if (int'(bus.CADDR) == 1000) hit = 1'b1;
            end
        end
        bus.coef_we = 1'b0;
        chk("abort_reached", int'(hit), 1);
        chk("ignored_write", got[502], model(502));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_cload", int'(bus.CLOAD), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_caddr", int'(bus.CADDR), 0);
        sb.delete();
        for (int i = 0; i < 64; i++) mcoef[i] = 0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_nodone", int'(bus.done), 0);
        end
    endtask

    initial begin
        int cur;
        vecs = '{'{1, 0, 0}, '{1, 255, 8}, '{1, 2047, 8}, '{1, 165, 4},
                 '{2, 255, -262144}, '{2, 1, -32768},
                 '{3, 1791, 262136}, '{3, 0, 0},
                 '{4, 288, 100}, '{4, 511, 100}, '{4, 256, 0}, '{4, 32, 0}, '{4, 544, 0}};
        bus.coef_we = 1'b0;
        bus.coef_idx = '0;
        bus.coef_data = '0;
        bus.start = 1'b0;
        bus.hold = 1'b0;
        for (int i = 0; i < 64; i++) mcoef[i] = 0;
        repeat (2) @(negedge clk);
        chk("rst_caddr", int'(bus.CADDR), 0);
        chk("rst_cin", int'(bus.CIN), 0);
        chk("rst_cload", int'(bus.CLOAD), 0);
        chk("rst_valid_in", int'(bus.valid_in), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        reset = 1'b0;
        @(negedge clk);
        run_stream(-1, -1, 0);
        cur = 0;
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].mode != cur) begin
                cur = vecs[i].mode;
                if (cur == 4) begin
                    load(4, 13);
                    run_stream(-1, 13, 100);
                end else begin
                    load(cur, -1);
                    run_stream(cur == 1 ? 300 : -1, -1, 0);
                end
            end
            chk($sformatf("vec%0d_cin_at_%0d", i, vecs[i].addr), got[vecs[i].addr], vecs[i].cin);
        end
        load(1, -1);
        run_abort();
        run_stream(-1, -1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
